// File: rtl/pri_drain_seq_if.sv
// Handshake bundle for pri_drain_seq: vector load side plus the index stream.
interface pri_drain_seq_if #(
  parameter int WIDTH = 256,
  parameter int IDXW  = 8,
  parameter int CNTW  = 9
);
  logic             load;
  logic [WIDTH-1:0] req_in;
  logic             load_rdy;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDXW-1:0]  idx_out;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  served_cnt;

  // Producer/consumer side that drives the block
  modport master (
    output load, req_in, idx_ready,
    input  load_rdy, idx_valid, idx_out, busy, done, served_cnt
  );

  // The drain sequencer itself
  modport slave (
    input  load, req_in, idx_ready,
    output load_rdy, idx_valid, idx_out, busy, done, served_cnt
  );
endinterface

// File: rtl/pri_drain_seq.sv
// Latches a request vector and emits the index of every set bit, highest
// first, one per valid/ready handshake. The index is registered, so the
// next index is computed from the post-clear vector in the same edge.
module pri_drain_seq #(
  parameter int WIDTH = 256,
  parameter int IDXW  = 8,
  parameter int CNTW  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  pri_drain_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;

  logic [WIDTH-1:0] pending_clr;
  logic [WIDTH-1:0] enc_in;
  logic [WIDTH-1:0] enc_rev;
  logic [WIDTH-1:0] enc_rev_iso;
  logic [WIDTH-1:0] enc_onehot;
  logic [IDXW-1:0]  enc_idx;
  logic [IDXW-1:0][WIDTH-1:0] enc_sel;

  // Pending vector with the currently granted bit removed
  assign pending_clr = pending_reg & ~(ONE << idx_reg);

  // The encoder looks at the incoming word while idle, else at the post-grant vector
  assign enc_in = (state_reg == ST_IDLE) ? bus.req_in : pending_clr;

  // Bit-reverse so the lowest-set-bit isolate (x & -x) picks the MSB
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign enc_rev[gi]    = enc_in[WIDTH-1-gi];
      assign enc_onehot[gi] = enc_rev_iso[WIDTH-1-gi];
    end
  endgenerate

  assign enc_rev_iso = enc_rev & (-enc_rev);

  // One-hot to binary: index bit b is the OR of all one-hot positions with bit b set
  genvar gb;
  generate
    for (gb = 0; gb < IDXW; gb++) begin : g_bin
      for (gi = 0; gi < WIDTH; gi++) begin : g_pos
        if (((gi >> gb) % 2) == 1) begin : g_on
          assign enc_sel[gb][gi] = enc_onehot[gi];
        end else begin : g_off
          assign enc_sel[gb][gi] = 1'b0;
        end
      end
      assign enc_idx[gb] = |enc_sel[gb];
    end
  endgenerate

  // Next-state, pending vector, registered index and served count
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.load) begin
          pending_next = bus.req_in;
          cnt_next     = '0;
          idx_next     = enc_idx;
          state_next   = (|bus.req_in) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (bus.idx_ready) begin
          pending_next = pending_clr;
          cnt_next     = cnt_reg + CNTW'(1);
          idx_next     = enc_idx;
          if (pending_clr == '0) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any drain in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.load_rdy   = (state_reg == ST_IDLE);
  assign bus.busy       = (state_reg == ST_DRAIN);
  assign bus.idx_valid  = (state_reg == ST_DRAIN);
  assign bus.done       = (state_reg == ST_DONE);
  assign bus.idx_out    = idx_reg;
  assign bus.served_cnt = cnt_reg;

endmodule

// File: tb/tb_pri_drain_seq.sv
// Bench for pri_drain_seq: vector table, directed corner sequences and
// randomized vectors checked against an ordered-index queue model.
module tb_pri_drain_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pri_drain_seq_if bus ();

  pri_drain_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] req;
    int           first;
    int           cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge; returns in cycle k+1
  task automatic do_load(input logic [255:0] v);
    bus.load   = 1'b1;
    bus.req_in = v;
    tick();
    bus.load   = 1'b0;
    bus.req_in = '0;
  endtask

  // Reference: indices of set bits, highest first
  task automatic build_order(input logic [255:0] v, output int q[$]);
    q = {};
    for (int i = 255; i >= 0; i--) begin
      if (v[i]) q.push_back(i);
    end
  endtask

  initial begin
    logic [255:0] v;
    int           n;
    int           q[$];
    int           served;
    int           cyc;
    bit           rdy;

    checks = 0;
    errors = 0;
    bus.load      = 1'b0;
    bus.req_in    = '0;
    bus.idx_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_load_rdy", 256'(bus.load_rdy), 256'd1);
    chk("reset_idx_valid", 256'(bus.idx_valid), 256'd0);
    chk("reset_busy", 256'(bus.busy), 256'd0);
    chk("reset_done", 256'(bus.done), 256'd0);
    chk("reset_idx_out", 256'(bus.idx_out), 256'd0);
    chk("reset_served", 256'(bus.served_cnt), 256'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven vectors ----------------
    tbl[0] = '{req: 256'h1, first: 0, cnt: 1};
    tbl[1] = '{req: 256'h1 << 255, first: 255, cnt: 1};
    tbl[2] = '{req: (256'h1 << 255) | 256'h5, first: 255, cnt: 3};
    tbl[3] = '{req: 256'hF0, first: 7, cnt: 4};
    tbl[4] = '{req: 256'h0, first: 0, cnt: 0};
    tbl[5] = '{req: {128'h0, {128{1'b1}}}, first: 127, cnt: 128};

    bus.idx_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      do_load(tbl[t].req);
      if (tbl[t].cnt > 0) begin
        chk($sformatf("tbl%0d_valid", t), 256'(bus.idx_valid), 256'd1);
        chk($sformatf("tbl%0d_first", t), 256'(bus.idx_out), 256'(tbl[t].first));
      end
      n = 0;
      while (!bus.done && n < 300) begin
        tick();
        n++;
      end
      chk($sformatf("tbl%0d_done_latency", t), 256'(n), 256'(tbl[t].cnt));
      chk($sformatf("tbl%0d_served", t), 256'(bus.served_cnt), 256'(tbl[t].cnt));
      tick();
    end

    // ---------------- basic order ----------------
    do_load((256'h1 << 255) | 256'h5);
    chk("basic_idx0", 256'(bus.idx_out), 256'd255);
    tick();
    chk("basic_idx1", 256'(bus.idx_out), 256'd2);
    tick();
    chk("basic_idx2", 256'(bus.idx_out), 256'd0);
    chk("basic_valid", 256'(bus.idx_valid), 256'd1);
    tick();
    chk("basic_done", 256'(bus.done), 256'd1);
    chk("basic_valid_drop", 256'(bus.idx_valid), 256'd0);
    chk("basic_served", 256'(bus.served_cnt), 256'd3);
    tick();
    chk("basic_done_pulse", 256'(bus.done), 256'd0);
    chk("basic_load_rdy", 256'(bus.load_rdy), 256'd1);
    chk("basic_served_hold", 256'(bus.served_cnt), 256'd3);

    // ---------------- backpressure ----------------
    bus.idx_ready = 1'b0;
    do_load(256'h0C);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), 256'(bus.idx_valid), 256'd1);
      chk($sformatf("bp_hold_idx%0d", i), 256'(bus.idx_out), 256'd3);
      chk($sformatf("bp_hold_served%0d", i), 256'(bus.served_cnt), 256'd0);
      tick();
    end
    bus.idx_ready = 1'b1;
    chk("bp_rel_idx0", 256'(bus.idx_out), 256'd3);
    tick();
    chk("bp_rel_idx1", 256'(bus.idx_out), 256'd2);
    tick();
    chk("bp_done", 256'(bus.done), 256'd1);
    chk("bp_served", 256'(bus.served_cnt), 256'd2);
    tick();

    // ---------------- empty vector ----------------
    do_load(256'h0);
    chk("empty_valid", 256'(bus.idx_valid), 256'd0);
    chk("empty_done", 256'(bus.done), 256'd1);
    chk("empty_served", 256'(bus.served_cnt), 256'd0);
    chk("empty_not_rdy", 256'(bus.load_rdy), 256'd0);
    tick();
    chk("empty_load_rdy", 256'(bus.load_rdy), 256'd1);
    chk("empty_done_clear", 256'(bus.done), 256'd0);

    // ---------------- full vector with ignored mid-drain load ----------------
    do_load({256{1'b1}});
    for (int i = 255; i >= 0; i--) begin
      chk($sformatf("full_idx%0d", i), 256'(bus.idx_out), 256'(i));
      if (i == 128) begin
        bus.load   = 1'b1;
        bus.req_in = 256'h1;
      end
      tick();
      bus.load   = 1'b0;
      bus.req_in = '0;
    end
    chk("full_done", 256'(bus.done), 256'd1);
    chk("full_served", 256'(bus.served_cnt), 256'd256);
    tick();
    chk("full_load_rdy", 256'(bus.load_rdy), 256'd1);
    chk("full_served_hold", 256'(bus.served_cnt), 256'd256);

    // ---------------- reset mid-drain ----------------
    do_load(256'hF0);
    tick();
    tick();
    chk("rst_pre_idx", 256'(bus.idx_out), 256'd5);
    chk("rst_pre_served", 256'(bus.served_cnt), 256'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 256'(bus.idx_valid), 256'd0);
    chk("rst_async_load_rdy", 256'(bus.load_rdy), 256'd1);
    chk("rst_async_served", 256'(bus.served_cnt), 256'd0);
    chk("rst_async_busy", 256'(bus.busy), 256'd0);
    chk("rst_async_idx", 256'(bus.idx_out), 256'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_no_done%0d", i), 256'(bus.done), 256'd0);
      chk($sformatf("rst_idle%0d", i), 256'(bus.load_rdy), 256'd1);
    end

    // ---------------- randomized vectors vs queue model ----------------
    for (int r = 0; r < 24; r++) begin
      int dens;
      dens = $urandom_range(0, 16);
      for (int i = 0; i < 256; i++) v[i] = ($urandom_range(0, 15) < dens);
      if (r == 0) v = '0;
      build_order(v, q);
      do_load(v);
      served = 0;
      cyc = 0;
      while (q.size() > 0 && cyc < 3000) begin
        chk($sformatf("rnd%0d_valid", r), 256'(bus.idx_valid), 256'd1);
        chk($sformatf("rnd%0d_idx", r), 256'(bus.idx_out), 256'(q[0]));
        chk($sformatf("rnd%0d_cnt", r), 256'(bus.served_cnt), 256'(served));
        rdy = ($urandom_range(0, 3) != 0) || (cyc > 2000);
        bus.idx_ready = rdy;
        if ($urandom_range(0, 7) == 0) begin
          bus.load   = 1'b1;
          bus.req_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        tick();
        bus.load   = 1'b0;
        bus.req_in = '0;
        if (rdy) begin
          void'(q.pop_front());
          served++;
        end
        cyc++;
      end
      if (q.size() > 0) begin
        chk($sformatf("rnd%0d_timeout", r), 256'(q.size()), 256'd0);
      end
      chk($sformatf("rnd%0d_done", r), 256'(bus.done), 256'd1);
      chk($sformatf("rnd%0d_final_cnt", r), 256'(bus.served_cnt), 256'(served));
      chk($sformatf("rnd%0d_valid_drop", r), 256'(bus.idx_valid), 256'd0);
      bus.idx_ready = 1'b1;
      tick();
      chk($sformatf("rnd%0d_load_rdy", r), 256'(bus.load_rdy), 256'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
